// File: rtl/puf_resp_serializer.sv
// puf_resp_serializer: takes one DATA_W-bit PUF response word over a
// valid/ready handshake and streams it out as bytes to the UART TX.
// Byte order set by MSB_FIRST; GAP_CYCLES idle cycles between bytes.
// Optional feature: define RESP_CHECKSUM_EN to append an XOR checksum
// byte after the last data byte (state CSUM). Default build omits it.

module puf_resp_serializer #(
  parameter int DATA_W     = 128,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              resp_valid,
  output logic              resp_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  // state | meaning
  // IDLE  | waiting for a response word, resp_ready high
  // SEND  | presenting current byte, waiting for tx_ready
  // GAP   | idle spacing between bytes, tx_valid low
  // CSUM  | presenting XOR checksum byte (RESP_CHECKSUM_EN only)
  // DONE  | one-cycle completion pulse, then back to IDLE
`ifdef RESP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SEND, GAP, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [7:0]        gap_cnt;
`ifdef RESP_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Byte that goes out first from a given word image.
  function automatic logic [7:0] head_byte(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) return v[DATA_W-1 -: 8];
    else           return v[7:0];
  endfunction

  // Shift register image once the current byte has been consumed.
  always_comb begin
    shreg_nxt = MSB_FIRST ? (shreg << 8) : (shreg >> 8);
  end

  // Serializer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      resp_ready <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RESP_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (resp_valid && resp_ready) begin
            shreg      <= resp_data;
            byte_cnt   <= '0;
            busy       <= 1'b1;
            resp_ready <= 1'b0;
            tx_valid   <= 1'b1;
            tx_data    <= head_byte(resp_data);
`ifdef RESP_CHECKSUM_EN
            csum       <= 8'h00;
`endif
            state      <= SEND;
          end
        end

        SEND: begin
          if (tx_ready) begin
            shreg    <= shreg_nxt;
            byte_cnt <= byte_cnt + CNT_W'(1);
`ifdef RESP_CHECKSUM_EN
            csum     <= csum ^ tx_data;
`endif
            if (byte_cnt == LAST_IDX) begin
`ifdef RESP_CHECKSUM_EN
              // Checksum follows immediately, no gap before it.
              tx_data <= csum ^ tx_data;
              state   <= CSUM;
`else
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              done     <= 1'b1;
              state    <= DONE;
`endif
            end else if (GAP_CYCLES > 0) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              gap_cnt  <= 8'(GAP_CYCLES);
              state    <= GAP;
            end else begin
              tx_data <= head_byte(shreg_nxt);
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          // Guard against a zero count so the FSM can never stall here.
          if (gap_cnt <= 8'd1) begin
            tx_valid <= 1'b1;
            tx_data  <= head_byte(shreg);
            state    <= SEND;
          end
        end

`ifdef RESP_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
`endif

        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          resp_ready <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state      <= IDLE;
          tx_valid   <= 1'b0;
          tx_data    <= 8'h00;
          resp_ready <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_serializer.sv
// Testbench for puf_resp_serializer: three instances (MSB-first, LSB-first,
// MSB-first with 3-cycle gap). Expected bytes are queued by the stimulus and
// popped by per-instance monitors on every accepted byte.

module tb_puf_resp_serializer;

`ifdef RESP_CHECKSUM_EN
  localparam int NB_EXP = 17;
`else
  localparam int NB_EXP = 16;
`endif

  localparam logic [127:0] W1 = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] W2 = 128'hFFEEDDCCBBAA99887766554433221100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] rd0, rd1, rd2;
  logic         rv0, rv1, rv2;
  logic         rr0, rr1, rr2;
  logic [7:0]   td0, td1, td2;
  logic         tv0, tv1, tv2;
  logic         tr0, tr1, tr2;
  logic         b0, b1, b2;
  logic         d0, d1, d2;

  puf_resp_serializer #(.DATA_W(128), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .resp_data(rd0), .resp_valid(rv0), .resp_ready(rr0),
    .tx_data(td0), .tx_valid(tv0), .tx_ready(tr0), .busy(b0), .done(d0));

  puf_resp_serializer #(.DATA_W(128), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .resp_data(rd1), .resp_valid(rv1), .resp_ready(rr1),
    .tx_data(td1), .tx_valid(tv1), .tx_ready(tr1), .busy(b1), .done(d1));

  puf_resp_serializer #(.DATA_W(128), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .resp_data(rd2), .resp_valid(rv2), .resp_ready(rr2),
    .tx_data(td2), .tx_valid(tv2), .tx_ready(tr2), .busy(b2), .done(d2));

  int n_cmp = 0;
  int n_bad = 0;
  int dcnt0 = 0, dcnt1 = 0, dcnt2 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the expected bytes of a word; nkeep < 16 models an aborted word.
  task automatic push_word(input int which, input logic [127:0] w, input bit msb,
                           input int nkeep);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      b = msb ? w[127-8*k -: 8] : w[8*k +: 8];
      x = x ^ b;
      if (k < nkeep) begin
        case (which)
          0: q0.push_back(b);
          1: q1.push_back(b);
          default: q2.push_back(b);
        endcase
      end
    end
`ifdef RESP_CHECKSUM_EN
    if (nkeep == 16) begin
      case (which)
        0: q0.push_back(x);
        1: q1.push_back(x);
        default: q2.push_back(x);
      endcase
    end
`endif
  endtask

  task automatic mon_one(input int which, input logic tv, input logic tr,
                         input logic [7:0] td);
    logic [7:0] e;
    if (tv && tr) begin
      case (which)
        0: begin
          if (q0.size() == 0) chk("u0_unexpected_byte", td, 8'hXX);
          else begin e = q0.pop_front(); chk("u0_byte", td, e); end
        end
        1: begin
          if (q1.size() == 0) chk("u1_unexpected_byte", td, 8'hXX);
          else begin e = q1.pop_front(); chk("u1_byte", td, e); end
        end
        default: begin
          if (q2.size() == 0) chk("u2_unexpected_byte", td, 8'hXX);
          else begin e = q2.pop_front(); chk("u2_byte", td, e); end
        end
      endcase
    end else if (!tv) begin
      chk("idle_tx_data_zero", td, 8'h00);
    end
  endtask

  // Monitor: sampled 1 time unit after the falling edge, once inputs settled.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      mon_one(0, tv0, tr0, td0);
      mon_one(1, tv1, tr1, td1);
      mon_one(2, tv2, tr2, td2);
      if (d0) dcnt0++;
      if (d1) dcnt1++;
      if (d2) dcnt2++;
    end
  end

  function automatic logic rr_of(input int which);
    case (which)
      0: return rr0;
      1: return rr1;
      default: return rr2;
    endcase
  endfunction

  function automatic logic d_of(input int which);
    case (which)
      0: return d0;
      1: return d1;
      default: return d2;
    endcase
  endfunction

  // Present a word; returns at the falling edge right after the accept edge.
  task automatic send(input int which, input logic [127:0] w);
    int n;
    @(negedge clk);
    case (which)
      0: begin rd0 = w; rv0 = 1'b1; end
      1: begin rd1 = w; rv1 = 1'b1; end
      default: begin rd2 = w; rv2 = 1'b1; end
    endcase
    n = 0;
    while (!rr_of(which) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", n, 0);
    @(negedge clk);
    case (which)
      0: rv0 = 1'b0;
      1: rv1 = 1'b0;
      default: rv2 = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int which);
    int n;
    n = 0;
    while (!d_of(which) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("done_timeout", n, 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1, n, first, last, zr, nb;
    rst = 1'b1;
    rd0 = '0; rd1 = '0; rd2 = '0;
    rv0 = 1'b0; rv1 = 1'b0; rv2 = 1'b0;
    tr0 = 1'b1; tr1 = 1'b1; tr2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_ready", rr0, 1);
    chk("rst_tx_valid", tv0, 0);
    chk("rst_tx_data", td0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    chk("rst_u1_ready", rr1, 1);
    chk("rst_u2_ready", rr2, 1);
    rst = 1'b0;

    // Basic MSB-first (u0) and LSB-first (u1) in lockstep.
    push_word(0, W1, 1'b1, 16);
    push_word(1, W1, 1'b0, 16);
    @(negedge clk);
    rd0 = W1; rd1 = W1; rv0 = 1'b1; rv1 = 1'b1;
    @(negedge clk);
    rv0 = 1'b0;
    // u1 keeps a second word valid through the whole first transfer.
    rd1 = W2;
    push_word(1, W2, 1'b0, 16);
    chk("latency_u0_valid", tv0, 1);
    chk("latency_u0_first", td0, 8'h01);
    chk("latency_u1_first", td1, 8'h10);
    chk("busy_after_accept", b0, 1);
    chk("ready_low_sending", rr0, 0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < NB_EXP; i++) begin
      if (tv0) cnt0++;
      if (tv1) cnt1++;
      chk("u1_ready_low_busy", rr1, 0);
      @(negedge clk);
    end
    chk("u0_consecutive_bytes", cnt0, NB_EXP);
    chk("u1_consecutive_bytes", cnt1, NB_EXP);
    chk("u0_done_pulse", d0, 1);
    chk("u0_valid_in_done", tv0, 0);
    chk("u1_done_pulse", d1, 1);
    chk("u1_ready_in_done", rr1, 0);
    @(negedge clk);
    chk("u0_done_cleared", d0, 0);
    chk("u0_busy_cleared", b0, 0);
    chk("u0_ready_back", rr0, 1);
    chk("u1_ready_idle", rr1, 1);
    @(negedge clk);
    rv1 = 1'b0;
    chk("u1_second_word_first", td1, 8'h00);
    chk("u1_second_word_valid", tv1, 1);
    wait_done(1);

    // Backpressure on byte 3 of u0.
    push_word(0, W1, 1'b1, 16);
    send(0, W1);
    repeat (3) @(negedge clk);
    tr0 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("bp_hold_data", td0, 8'h04);
      chk("bp_hold_valid", tv0, 1);
      @(negedge clk);
    end
    tr0 = 1'b1;
    @(negedge clk);
    chk("bp_next_byte", td0, 8'h05);
    wait_done(0);

    // Gap of 3 cycles between bytes on u2.
    push_word(2, W1, 1'b1, 16);
    send(2, W1);
    first = -1; last = -1; zr = 0; nb = 0; n = 0;
    while (!d2 && n < 300) begin
      if (tv2) begin
        if (nb > 0) chk("gap_len", zr, (nb < 16) ? 3 : 0);
        if (first < 0) first = n;
        last = n;
        nb++;
        zr = 0;
      end else begin
        zr++;
      end
      n++;
      @(negedge clk);
    end
    chk("gap_timeout", (n < 300) ? 1 : 0, 1);
    chk("gap_span", last - first + 1, 61 + (NB_EXP - 16));
    chk("gap_byte_count", nb, NB_EXP);
    @(negedge clk);

    // Reset after byte index 5 accepted, then a fresh word.
    push_word(0, W1, 1'b1, 6);
    send(0, W1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", tv0, 0);
    chk("midrst_resp_ready", rr0, 1);
    chk("midrst_tx_data", td0, 0);
    chk("midrst_busy", b0, 0);
    @(negedge clk);
    rst = 1'b0;
    push_word(0, W2, 1'b1, 16);
    send(0, W2);
    chk("post_rst_first", td0, 8'hFF);
    wait_done(0);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("u0_done_count", dcnt0, 3);
    chk("u1_done_count", dcnt1, 2);
    chk("u2_done_count", dcnt2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
